// File: rtl/sdram_req_scheduler_if.sv
// Client/SDRAM bus bundle for the round-robin SDRAM request scheduler.
// Signal names match the scheduler's original flat port list.
interface sdram_req_scheduler_if #(
  parameter int N = 4
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic              rt_urgent;
  logic [N-1:0]      req_rd;
  logic [N-1:0]      req_wr;
  logic [22*N-1:0]   req_addr;
  logic [128*N-1:0]  req_wrdata;
  logic [16*N-1:0]   req_be;
  logic [N-1:0]      cl_wait;
  logic [N-1:0]      cl_ac;
  logic [127:0]      cl_rddata;
  logic [21:0]       ar_addr;
  logic [15:0]       ar_be;
  logic              ar_read;
  logic              ar_write;
  logic [127:0]      ar_wrdata;
  logic              ar_ac;
  logic [127:0]      ar_rddata;
  logic              grant_valid;
  logic [IDW-1:0]    grant_id;

  modport slave (
    input  rt_urgent, req_rd, req_wr, req_addr, req_wrdata, req_be, ar_ac, ar_rddata,
    output cl_wait, cl_ac, cl_rddata, ar_addr, ar_be, ar_read, ar_write, ar_wrdata,
           grant_valid, grant_id
  );

  modport master (
    output rt_urgent, req_rd, req_wr, req_addr, req_wrdata, req_be, ar_ac, ar_rddata,
    input  cl_wait, cl_ac, cl_rddata, ar_addr, ar_be, ar_read, ar_write, ar_wrdata,
           grant_valid, grant_id
  );
endinterface

// File: rtl/sdram_req_scheduler.sv
// Round-robin SDRAM access scheduler: one client owns the ar_* port per grant,
// bursts are bounded, and an urgency input lets client 0 preempt at ack boundaries.
module sdram_req_scheduler #(
  parameter int N         = 4,
  parameter int MAX_BURST = 8
) (
  input logic                 clk,
  input logic                 reset,
  sdram_req_scheduler_if.slave bus
);
  localparam int          IDW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned N_U = N;
  localparam logic [7:0]  MB8 = 8'(MAX_BURST);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [IDW-1:0] last_id_q, last_id_d;
  logic [7:0]     beat_cnt_q, beat_cnt_d;

  logic [N-1:0]   pending;
  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [7:0]     beat_inc;

  always_comb begin
    pending = bus.req_rd | bus.req_wr;
  end

  // Urgent client 0 overrides rotation; otherwise scan from last_id+1 with wrap.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    if (bus.rt_urgent && pending[0]) begin
      win_found = 1'b1;
    end else begin
      for (int unsigned k = 1; k <= N_U; k++) begin
        idx = (32'(last_id_q) + k) % N_U;
        if (!win_found && pending[idx[IDW-1:0]]) begin
          win_found = 1'b1;
          win_id    = idx[IDW-1:0];
        end
      end
    end
  end

  always_comb begin
    beat_inc = (beat_cnt_q >= MB8) ? beat_cnt_q : beat_cnt_q + 8'd1;
  end

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    last_id_d  = last_id_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d    = GRANT;
          grant_id_d = win_id;
          last_id_d  = win_id;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (!pending[grant_id_q]) begin
          state_d = IDLE;
        end else if (bus.ar_ac) begin
          beat_cnt_d = beat_inc;
          if (beat_inc == MB8 ||
              (bus.rt_urgent && pending[0] && grant_id_q != '0)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ar_addr     = '0;
    bus.ar_be       = '1;
    bus.ar_read     = 1'b0;
    bus.ar_write    = 1'b0;
    bus.ar_wrdata   = '0;
    bus.cl_wait     = '1;
    bus.cl_ac       = '0;
    bus.cl_rddata   = bus.ar_rddata;
    bus.grant_valid = (state_q == GRANT);
    bus.grant_id    = grant_id_q;
    if (state_q == GRANT) begin
      bus.ar_addr             = bus.req_addr[22*grant_id_q +: 22];
      bus.ar_be               = bus.req_be[16*grant_id_q +: 16];
      bus.ar_wrdata           = bus.req_wrdata[128*grant_id_q +: 128];
      bus.ar_write            = bus.req_wr[grant_id_q];
      bus.ar_read             = bus.req_rd[grant_id_q] & ~bus.req_wr[grant_id_q];
      bus.cl_wait[grant_id_q] = 1'b0;
      bus.cl_ac[grant_id_q]   = bus.ar_ac;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      last_id_q  <= IDW'(N - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_id_q  <= last_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end
endmodule

// File: tb/tb_sdram_req_scheduler.sv
// Bench for sdram_req_scheduler: two instances (burst 2 and burst 8) share stimulus
// and are compared against a grant-ownership model of the scheduling rules.
module tb_sdram_req_scheduler;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              rt_urgent;
  logic [N-1:0]      req_rd, req_wr;
  logic [22*N-1:0]   req_addr;
  logic [128*N-1:0]  req_wrdata;
  logic [16*N-1:0]   req_be;
  logic              ar_ac;
  logic [127:0]      ar_rddata;

  sdram_req_scheduler_if #(.N(N)) bus_a ();
  sdram_req_scheduler_if #(.N(N)) bus_b ();

  assign bus_a.rt_urgent = rt_urgent;   assign bus_b.rt_urgent = rt_urgent;
  assign bus_a.req_rd = req_rd;         assign bus_b.req_rd = req_rd;
  assign bus_a.req_wr = req_wr;         assign bus_b.req_wr = req_wr;
  assign bus_a.req_addr = req_addr;     assign bus_b.req_addr = req_addr;
  assign bus_a.req_wrdata = req_wrdata; assign bus_b.req_wrdata = req_wrdata;
  assign bus_a.req_be = req_be;         assign bus_b.req_be = req_be;
  assign bus_a.ar_ac = ar_ac;           assign bus_b.ar_ac = ar_ac;
  assign bus_a.ar_rddata = ar_rddata;   assign bus_b.ar_rddata = ar_rddata;

  sdram_req_scheduler #(.N(N), .MAX_BURST(2)) u_dut_b2 (.clk(clk), .reset(reset), .bus(bus_a));
  sdram_req_scheduler #(.N(N), .MAX_BURST(8)) u_dut_b8 (.clk(clk), .reset(reset), .bus(bus_b));

  logic         o_valid [2];
  logic [1:0]   o_id    [2];
  logic [3:0]   o_wait  [2];
  logic [3:0]   o_ac    [2];
  logic         o_rd    [2];
  logic         o_wr    [2];
  logic [21:0]  o_addr  [2];
  logic [15:0]  o_be    [2];
  logic [127:0] o_data  [2];
  logic [127:0] o_rdd   [2];

  assign o_valid[0] = bus_a.grant_valid; assign o_valid[1] = bus_b.grant_valid;
  assign o_id[0]    = bus_a.grant_id;    assign o_id[1]    = bus_b.grant_id;
  assign o_wait[0]  = bus_a.cl_wait;     assign o_wait[1]  = bus_b.cl_wait;
  assign o_ac[0]    = bus_a.cl_ac;       assign o_ac[1]    = bus_b.cl_ac;
  assign o_rd[0]    = bus_a.ar_read;     assign o_rd[1]    = bus_b.ar_read;
  assign o_wr[0]    = bus_a.ar_write;    assign o_wr[1]    = bus_b.ar_write;
  assign o_addr[0]  = bus_a.ar_addr;     assign o_addr[1]  = bus_b.ar_addr;
  assign o_be[0]    = bus_a.ar_be;       assign o_be[1]    = bus_b.ar_be;
  assign o_data[0]  = bus_a.ar_wrdata;   assign o_data[1]  = bus_b.ar_wrdata;
  assign o_rdd[0]   = bus_a.cl_rddata;   assign o_rdd[1]   = bus_b.cl_rddata;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: which client owns the port (-1 none), rotation pointer, acks this grant.
  int m_owner [2];
  int m_last  [2];
  int m_gid   [2];
  int m_beats [2];
  int mb      [2] = '{2, 8};

  logic         e_valid [2];
  logic [1:0]   e_id    [2];
  logic [3:0]   e_wait  [2];
  logic [3:0]   e_ac    [2];
  logic         e_rd    [2];
  logic         e_wr    [2];
  logic [21:0]  e_addr  [2];
  logic [15:0]  e_be    [2];
  logic [127:0] e_data  [2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k] = -1; m_last[k] = N - 1; m_gid[k] = 0; m_beats[k] = 0;
    end
  endfunction

  function automatic void model_clock();
    logic [N-1:0] pend;
    pend = req_rd | req_wr;
    for (int k = 0; k < 2; k++) begin
      if (m_owner[k] < 0) begin
        int w = -1;
        if (rt_urgent && pend[0]) w = 0;
        else
          for (int s = 1; s <= N; s++)
            if (w < 0 && pend[(m_last[k] + s) % N]) w = (m_last[k] + s) % N;
        if (w >= 0) begin
          m_owner[k] = w; m_last[k] = w; m_gid[k] = w; m_beats[k] = 0;
        end
      end else begin
        int g = m_owner[k];
        if (!pend[g]) m_owner[k] = -1;
        else if (ar_ac) begin
          if (m_beats[k] < mb[k]) m_beats[k]++;
          if (m_beats[k] == mb[k] || (rt_urgent && pend[0] && g != 0)) m_owner[k] = -1;
        end
      end
    end
  endfunction

  function automatic void compute_expected();
    for (int k = 0; k < 2; k++) begin
      e_valid[k] = (m_owner[k] >= 0);
      e_id[k]    = 2'(m_gid[k]);
      e_wait[k]  = 4'hF; e_ac[k] = 4'h0; e_rd[k] = 1'b0; e_wr[k] = 1'b0;
      e_addr[k]  = '0;   e_be[k] = 16'hFFFF; e_data[k] = '0;
      if (m_owner[k] >= 0) begin
        int g = m_owner[k];
        e_wait[k][g] = 1'b0;
        e_ac[k][g]   = ar_ac;
        e_wr[k]      = req_wr[g];
        e_rd[k]      = req_rd[g] & ~req_wr[g];
        e_addr[k]    = req_addr[22*g +: 22];
        e_be[k]      = req_be[16*g +: 16];
        e_data[k]    = req_wrdata[128*g +: 128];
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!reset) model_clock();
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    compute_expected();
  endtask

  task automatic clear_inputs();
    rt_urgent = 1'b0; req_rd = '0; req_wr = '0; ar_ac = 1'b0;
    req_addr = '0; req_wrdata = '0; req_be = '1; ar_rddata = '0;
  endtask

  task automatic drain();
    clear_inputs();
    repeat (3) begin settle(); tick(); end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({o_valid[k], o_wait[k], o_ac[k], o_rd[k], o_wr[k]} !== {1'b0, 4'hF, 4'h0, 2'b00})
        $display("FAIL reset_ctl inst%0d: got %b required %b", k,
                 {o_valid[k], o_wait[k], o_ac[k], o_rd[k], o_wr[k]}, {1'b0, 4'hF, 4'h0, 2'b00});
      else n_pass++;
      n_checks++;
      if ({o_be[k], o_addr[k], o_data[k], o_id[k]} !== {16'hFFFF, 22'h0, 128'h0, 2'd0})
        $display("FAIL reset_bus inst%0d: be=%h addr=%h data=%h id=%0d", k,
                 o_be[k], o_addr[k], o_data[k], o_id[k]);
      else n_pass++;
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    int seq[$], acks[$], gaps[$];
    int idle_run;
    logic prev_valid;
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    idle_run = 0; prev_valid = 1'b0;
    clear_inputs();
    req_rd = 4'hF;
    for (int c = 0; c < 36; c++) begin
      ar_addr_fill();
      ar_ac = (c % 3 == 2);
      settle();
      if (o_valid[0] && !prev_valid) begin
        seq.push_back(int'(o_id[0])); acks.push_back(0);
        if (seq.size() > 1) gaps.push_back(idle_run);
        idle_run = 0;
      end
      if (!o_valid[0]) idle_run++;
      if (o_valid[0] && o_ac[0] != 4'h0) acks[acks.size()-1]++;
      prev_valid = o_valid[0];
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if ({o_valid[k], o_id[k], o_wait[k], o_ac[k], o_rd[k]} !==
            {e_valid[k], e_id[k], e_wait[k], e_ac[k], e_rd[k]})
          $display("FAIL rr_cycle%0d inst%0d: got v/id/wait/ac/rd %b required %b", c, k,
                   {o_valid[k], o_id[k], o_wait[k], o_ac[k], o_rd[k]},
                   {e_valid[k], e_id[k], e_wait[k], e_ac[k], e_rd[k]});
        else n_pass++;
      end
      tick();
    end
    n_checks++;
    if (seq.size() < 5) $display("FAIL rr_grant_count: got %0d required >=5", seq.size());
    else n_pass++;
    for (int i = 0; i < 5 && i < seq.size(); i++) begin
      n_checks++;
      if (seq[i] != exp_seq[i]) $display("FAIL rr_order[%0d]: got %0d required %0d", i, seq[i], exp_seq[i]);
      else n_pass++;
    end
    for (int i = 0; i < 4 && i < acks.size(); i++) begin
      n_checks++;
      if (acks[i] != 2) $display("FAIL rr_acks[%0d]: got %0d required 2", i, acks[i]);
      else n_pass++;
    end
    for (int i = 0; i < 4 && i < gaps.size(); i++) begin
      n_checks++;
      if (gaps[i] != 1) $display("FAIL rr_bubble[%0d]: got %0d required 1", i, gaps[i]);
      else n_pass++;
    end
    drain();
  endtask

  task automatic ar_addr_fill();
    for (int i = 0; i < N; i++) req_addr[22*i +: 22] = 22'($urandom);
  endtask

  task automatic test_write();
    logic [127:0] wdat;
    wdat = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
    clear_inputs();
    req_wr[2] = 1'b1;
    req_addr[22*2 +: 22] = 22'h00ABC;
    req_wrdata[128*2 +: 128] = wdat;
    req_be[16*2 +: 16] = 16'h00FF;
    settle(); tick();
    settle();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({o_wr[k], o_rd[k], o_wait[k]} !== {1'b1, 1'b0, 4'b1011})
        $display("FAIL wr_ctl inst%0d: got wr/rd/wait %b required %b", k,
                 {o_wr[k], o_rd[k], o_wait[k]}, {1'b1, 1'b0, 4'b1011});
      else n_pass++;
      n_checks++;
      if ({o_addr[k], o_be[k], o_data[k]} !== {22'h00ABC, 16'h00FF, wdat})
        $display("FAIL wr_fields inst%0d: addr=%h be=%h data=%h", k, o_addr[k], o_be[k], o_data[k]);
      else n_pass++;
    end
    tick();
    ar_ac = 1'b1;
    settle();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (o_ac[k] !== 4'b0100) $display("FAIL wr_ack inst%0d: got %b required 0100", k, o_ac[k]);
      else n_pass++;
    end
    tick();
    ar_ac = 1'b0; req_wr = '0;
    settle();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({o_valid[k], o_wr[k]} !== {e_valid[k], e_wr[k]} || e_valid[k] !== 1'b1)
        $display("FAIL wr_release_cycle inst%0d: got v/wr %b required %b", k,
                 {o_valid[k], o_wr[k]}, {e_valid[k], e_wr[k]});
      else n_pass++;
    end
    tick();
    settle();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (o_valid[k] !== 1'b0) $display("FAIL wr_released inst%0d: got %b required 0", k, o_valid[k]);
      else n_pass++;
    end
    tick();
    drain();
  endtask

  task automatic test_preempt();
    int extra;
    clear_inputs();
    req_rd[1] = 1'b1;
    req_addr[22*1 +: 22] = 22'($urandom);
    settle(); tick();
    for (int i = 0; i < 4; i++) begin
      ar_ac = (i % 2 == 0);
      settle(); tick();
    end
    ar_ac = 1'b0; rt_urgent = 1'b1; req_rd[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_checks++;
      if ({o_valid[1], o_id[1]} !== {1'b1, 2'd1})
        $display("FAIL pre_hold%0d: got v/id %b required 101", i, {o_valid[1], o_id[1]});
      else n_pass++;
      tick();
    end
    ar_ac = 1'b1;
    settle();
    extra = 0;
    if (o_ac[1][1]) extra++;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (o_ac[k] !== e_ac[k]) $display("FAIL pre_ack inst%0d: got %b required %b", k, o_ac[k], e_ac[k]);
      else n_pass++;
    end
    tick();
    ar_ac = 1'b0;
    settle();
    n_checks++;
    if (o_valid[1] !== 1'b0) $display("FAIL pre_exit: got valid %b required 0", o_valid[1]);
    else n_pass++;
    tick();
    settle();
    n_checks++;
    if ({o_valid[1], o_id[1], o_wait[1]} !== {1'b1, 2'd0, 4'b1110})
      $display("FAIL pre_grant0: got v/id/wait %b required 1001110", {o_valid[1], o_id[1], o_wait[1]});
    else n_pass++;
    tick();
    ar_ac = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      if (o_ac[1][1]) extra++;
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if ({o_valid[k], o_id[k], o_ac[k]} !== {e_valid[k], e_id[k], e_ac[k]})
          $display("FAIL pre_after%0d inst%0d: got %b required %b", i, k,
                   {o_valid[k], o_id[k], o_ac[k]}, {e_valid[k], e_id[k], e_ac[k]});
        else n_pass++;
      end
      tick();
    end
    n_checks++;
    if (extra != 1) $display("FAIL pre_one_more_ack: got %0d required 1", extra);
    else n_pass++;
    drain();
  endtask

  task automatic test_rd_wr_both();
    clear_inputs();
    req_rd[3] = 1'b1; req_wr[3] = 1'b1;
    req_addr[22*3 +: 22] = 22'($urandom);
    settle(); tick();
    settle();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({o_wr[k], o_rd[k], o_id[k]} !== {1'b1, 1'b0, 2'd3})
        $display("FAIL both_rw inst%0d: got wr/rd/id %b required 1011", k, {o_wr[k], o_rd[k], o_id[k]});
      else n_pass++;
    end
    tick();
    drain();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    req_rd = 4'hF;
    ar_addr_fill();
    settle(); tick();
    settle();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({o_valid[k], o_rd[k]} !== 2'b11) $display("FAIL rstmid_pre inst%0d: got v/rd %b required 11", k, {o_valid[k], o_rd[k]});
      else n_pass++;
    end
    #1 reset = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({o_valid[k], o_wait[k], o_ac[k], o_rd[k], o_wr[k], o_be[k], o_addr[k]} !==
          {1'b0, 4'hF, 4'h0, 2'b00, 16'hFFFF, 22'h0})
        $display("FAIL rstmid_async inst%0d: v=%b wait=%b rd=%b be=%h addr=%h", k,
                 o_valid[k], o_wait[k], o_rd[k], o_be[k], o_addr[k]);
      else n_pass++;
    end
    #1 reset = 1'b0;
    tick();
    settle();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({o_valid[k], o_id[k]} !== {1'b1, 2'd0})
        $display("FAIL rstmid_first inst%0d: got v/id %b required 100", k, {o_valid[k], o_id[k]});
      else n_pass++;
    end
    tick();
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rt_urgent  = ($urandom % 6 == 0);
      req_rd     = 4'($urandom) & 4'($urandom);
      req_wr     = 4'($urandom) & 4'($urandom) & 4'($urandom);
      ar_addr_fill();
      for (int i = 0; i < N; i++) begin
        req_wrdata[128*i +: 128] = rand128();
        req_be[16*i +: 16] = 16'($urandom);
      end
      ar_ac      = $urandom % 2 == 0;
      ar_rddata  = rand128();
      settle();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if ({o_valid[k], o_id[k], o_wait[k], o_ac[k], o_rd[k], o_wr[k]} !==
            {e_valid[k], e_id[k], e_wait[k], e_ac[k], e_rd[k], e_wr[k]})
          $display("FAIL rnd_ctl c%0d inst%0d: got %b required %b", c, k,
                   {o_valid[k], o_id[k], o_wait[k], o_ac[k], o_rd[k], o_wr[k]},
                   {e_valid[k], e_id[k], e_wait[k], e_ac[k], e_rd[k], e_wr[k]});
        else n_pass++;
        n_checks++;
        if ({o_addr[k], o_be[k], o_data[k]} !== {e_addr[k], e_be[k], e_data[k]})
          $display("FAIL rnd_bus c%0d inst%0d: got addr=%h be=%h required addr=%h be=%h", c, k,
                   o_addr[k], o_be[k], e_addr[k], e_be[k]);
        else n_pass++;
        n_checks++;
        if (o_rdd[k] !== ar_rddata)
          $display("FAIL rnd_rddata c%0d inst%0d: got %h required %h", c, k, o_rdd[k], ar_rddata);
        else n_pass++;
      end
      tick();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_write();
    test_preempt();
    test_rd_wr_both();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sdram_req_scheduler.md
# sdram_req_scheduler

Round-robin SDRAM access scheduler sitting between the frame-time clients (line buffer, I2S PCM fetch, background/DFJK, score/note draw) and the single 128-bit Avalon-style SDRAM port (`ar_*`). It grants one client at a time using the existing per-client `wait`/`ac` handshake. It bounds each grant to a burst of accesses and lets a real-time urgency input give client 0 (line buffer) strict priority, with preemption at access boundaries. It replaces hard-wired state-based muxing, so the display and audio paths no longer depend on fixed DrawX windows for SDRAM time.

## Interface
- `N`, 4: number of clients; client 0 is the real-time client.
- `MAX_BURST`, 8: maximum acknowledged accesses per grant (1..255).
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `rt_urgent`  in  1: when high, client 0 has strict priority and preempts other grants.
- `req_rd`  in  N: per-client read request.
- `req_wr`  in  N: per-client write request.
- `req_addr`  in  22*N: client i at bits [22i+21:22i].
- `req_wrdata`  in  128*N: client i at bits [128i+127:128i].
- `req_be`  in  16*N: client i byte enables at bits [16i+15:16i].
- `cl_wait`  out  N: 1 = not granted; 0 only for the granted client.
- `cl_ac`  out  N: acknowledge, forwarded to the granted client only.
- `cl_rddata`  out  128: `ar_rddata` broadcast to all clients.
- `ar_addr`  out  22; `ar_be`  out  16; `ar_read`  out  1; `ar_write`  out  1; `ar_wrdata`  out  128: SDRAM-side request.
- `ar_ac`  in  1; `ar_rddata`  in  128: SDRAM-side acknowledge and read data.
- `grant_valid`  out  1; `grant_id`  out  $clog2(N): current grant, for debug and monitors.

## Operation
- States: IDLE and GRANT. Registers: `state`, `grant_id`, `last_id`, and `beat_cnt` (8 bits).
- Pending for client i is `req_rd[i] | req_wr[i]`.
- IDLE, winner selection:
  - If `rt_urgent` and client 0 is pending, client 0 wins.
  - Otherwise the first pending client searching `last_id+1, last_id+2, …` with modulo-N wrap wins.
  - If nothing is pending, stay in IDLE.
  - On a win: load `grant_id`, set `last_id` to the winner, clear `beat_cnt`, and go to GRANT.
- GRANT, outputs driven from the granted client g:
  - `ar_addr`, `ar_be`, and `ar_wrdata` come from client g.
  - `ar_write` = `req_wr[g]`.
  - `ar_read` = `req_rd[g] & ~req_wr[g]`. Write wins if both are high.
  - `cl_wait[g]`=0 and `cl_ac[g]`=`ar_ac`.
- GRANT exit to IDLE on the cycle after any of the following:
  - an `ar_ac` that makes `beat_cnt` reach `MAX_BURST`;
  - an `ar_ac` while `rt_urgent`=1, client 0 is pending, and g≠0 (preemption at the access boundary; an in-flight access is never cut);
  - a cycle in GRANT where client g is not pending (release; no `ar_ac` is expected on that cycle).
- Outside GRANT, or in IDLE: `ar_read`=`ar_write`=0, `ar_addr`=0, `ar_wrdata`=0, `ar_be`=16'hFFFF, all `cl_wait`=1, all `cl_ac`=0.
- `cl_rddata` = `ar_rddata` at all times.
- `beat_cnt` increments on each `ar_ac` in GRANT and saturates at `MAX_BURST`.
- An `ar_ac` arriving in IDLE is ignored; it is not forwarded to any client.

## Timing
- Reset, asynchronous:
  - `state`=IDLE, `grant_id`=0, `last_id`=N-1 (client 0 is first in rotation), `beat_cnt`=0.
  - `grant_valid`=0, all `cl_wait`=1, all `cl_ac`=0, `ar_read`=`ar_write`=0, `ar_be`=16'hFFFF, `ar_addr`=0, `ar_wrdata`=0.
- Grant latency: request seen in IDLE at cycle t gives `cl_wait`=0 and `ar_*` driven at t+1.
- Handshake:
  - `cl_ac` is combinational from `ar_ac`, with zero added latency.
  - Clients hold the request and its fields stable until `cl_ac`.
- Re-arbitration costs exactly one IDLE bubble cycle between grants.
- `rt_urgent` rising mid-access: the current access completes, then client 0 is granted 2 cycles after that `ar_ac` (one exit cycle plus one IDLE cycle).
- Reset asserted mid-access: outputs drop immediately. The SDRAM controller must tolerate the withdrawn request.

## Test plan
- Reset, then all four clients request reads with `ar_ac` every 3rd cycle and `MAX_BURST`=2:
  - grants go 0,1,2,3,0, with 2 acks each;
  - `cl_wait` is low only for the granted client;
  - one IDLE cycle separates grants.
- Client 2 writes addr 22'h00ABC, data 128'hDEAD…BEEF, be 16'h00FF:
  - `ar_write`=1 with matching addr, data, and be at t+1;
  - `cl_ac[2]` pulses coincident with `ar_ac`;
  - after the client drops its request, `grant_valid`=0 on the next cycle.
- Client 1 in a burst, `rt_urgent`=1 and client 0 requesting:
  - client 1 receives exactly one more ack;
  - client 0 is granted 2 cycles after that ack.
- Client 3 drives `req_rd`=`req_wr`=1: `ar_write`=1 and `ar_read`=0.
- Assert `reset` while `ar_read`=1 with a grant held:
  - all outputs take reset values in the same cycle;
  - after release, client 0 is granted first.
